imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/y86_pkg.sv | 17 +
 rtl/loader_xsum.sv | 25 ++
 rtl/imem_loader.sv | 135 +++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared loader definitions: FSM state encoding, frame header size, default memory size.
package y86_pkg;

  typedef enum logic [2:0] {
    S_ALO,
    S_AHI,
    S_LLO,
    S_LHI,
    S_DATA,
    S_CSUM,
    S_DONE
  } ld_state_t;

  localparam int HDR_BYTES     = 4;
  localparam int MEM_BYTES_DEF = 2048;

endpackage

// File: rtl/loader_xsum.sv
// Running XOR of accepted frame bytes; clr together with acc seeds the sum with din.
// zero is combinational from the stored sum and is read during the frame's done cycle.
module loader_xsum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       acc,
  input  logic [7:0] din,
  output logic       zero
);

  logic [7:0] sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sum <= 8'h00;
    else if (clr)
      sum <= acc ? din : 8'h00;
    else if (acc)
      sum <= sum ^ din;
  end

  assign zero = (sum == 8'h00);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream frame loader into instruction memory; payload writes appear one cycle after accept,
// in_ready drops only in the done cycle. IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic        load_done,
  output logic        range_err,
  output logic        chk_err
);

  localparam logic [17:0] MEM_LIMIT = 18'(MEM_BYTES);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam ld_state_t TAIL_STATE = S_CSUM;
`else
  localparam ld_state_t TAIL_STATE = S_DONE;
`endif

  ld_state_t   state, next_state;
  logic        accept;
  logic [15:0] start_addr, len, offset;
  logic [16:0] target;
  logic        in_range, last_byte;

  assign accept    = in_valid && in_ready;
  // 17-bit sum so a start near 0xFFFF cannot wrap back into valid memory
  assign target    = {1'b0, start_addr} + {1'b0, offset};
  assign in_range  = ({1'b0, target} < MEM_LIMIT);
  assign last_byte = (({1'b0, offset} + 17'd1) == {1'b0, len});

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_ALO;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b1;
    busy       = 1'b1;
    load_done  = 1'b0;
    case (state)
      S_ALO: begin
        busy = 1'b0;
        if (accept) next_state = S_AHI;
      end
      S_AHI: if (accept) next_state = S_LLO;
      S_LLO: if (accept) next_state = S_LHI;
      S_LHI: begin
        if (accept)
          next_state = ({in_data, len[7:0]} != 16'd0) ? S_DATA : TAIL_STATE;
      end
      S_DATA: if (accept && last_byte) next_state = TAIL_STATE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: if (accept) next_state = S_DONE;
`endif
      S_DONE: begin
        in_ready   = 1'b0;
        load_done  = 1'b1;
        next_state = S_ALO;
      end
      default: next_state = S_ALO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_addr <= 16'd0;
      len        <= 16'd0;
      offset     <= 16'd0;
      mem_we     <= 1'b0;
      mem_addr   <= 64'd0;
      mem_wdata  <= 8'd0;
      range_err  <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (accept) begin
        case (state)
          S_ALO: begin
            start_addr[7:0] <= in_data;
            range_err       <= 1'b0;
          end
          S_AHI: start_addr[15:8] <= in_data;
          S_LLO: len[7:0] <= in_data;
          S_LHI: begin
            len[15:8] <= in_data;
            offset    <= 16'd0;
          end
          S_DATA: begin
            offset <= offset + 16'd1;
            // out-of-range bytes are still consumed so the stream stays framed
            if (in_range) begin
              mem_we    <= 1'b1;
              mem_addr  <= {47'd0, target};
              mem_wdata <= in_data;
            end else begin
              range_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic xsum_zero;

  loader_xsum u_xsum (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept && (state == S_ALO)),
    .acc  (accept),
    .din  (in_data),
    .zero (xsum_zero)
  );

  assign chk_err = load_done && !xsum_zero;
`else
  assign chk_err = 1'b0;
`endif

endmodule
